// File: rtl/out_display_pkg.sv
// Shared types and constants for the BCD display controller.
// Holds the converter FSM encoding, 7-segment glyphs and the double-dabble digit adjust.
package out_display_pkg;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_CONVERT = 1'b1
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;

    function automatic logic [3:0] dd_adjust(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to 7-segment decoder; non-decimal codes go dark.
module seg7_decode
    import out_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = 7'b0000000;
        case (bcd)
            4'd0: seg_c = SEG_0;
            4'd1: seg_c = SEG_1;
            4'd2: seg_c = SEG_2;
            4'd3: seg_c = SEG_3;
            4'd4: seg_c = SEG_4;
            4'd5: seg_c = SEG_5;
            4'd6: seg_c = SEG_6;
            4'd7: seg_c = SEG_7;
            4'd8: seg_c = SEG_8;
            4'd9: seg_c = SEG_9;
            default: seg_c = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/out_display_ctrl.sv
// Binary-to-BCD converter (serial double dabble) driving a multiplexed 7-segment display.
// A load during conversion is parked in a one-deep pending slot (last value wins).
module out_display_ctrl
    import out_display_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned SCAN_DIV = 1024,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_en,
    input  logic                i_load_enable,
    input  logic [WIDTH-1:0]    i_load_data,
    output logic [4*DIGITS-1:0] o_bcd,
    output logic [6:0]          o_seg,
    output logic [DIGITS-1:0]   o_digit_sel,
    output logic                o_busy
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    shift_q, shift_d;
    logic [BCD_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [WIDTH-1:0]    pend_data_q, pend_data_d;
    logic [BCD_W-1:0]    bcd_d;
    logic [SCAN_W-1:0]   scan_q, scan_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [6:0]          seg_d;
    logic [DIGITS-1:0]   sel_d;
    logic                busy_d;

    logic [BCD_W-1:0]       acc_adj_c;
    logic [BCD_W+WIDTH-1:0] step_c;
    logic [3:0]             cur_digit_c;
    logic [6:0]             dec_seg_c;
    logic                   nz_above_c;

    // One double-dabble step: adjust every digit, then shift the whole chain left
    always_comb begin
        acc_adj_c = acc_q;
        for (int d = 0; d < int'(DIGITS); d++) begin
            acc_adj_c[4*d +: 4] = dd_adjust(acc_q[4*d +: 4]);
        end
        step_c = {acc_adj_c, shift_q} << 1;
    end

    // Converter FSM, pending slot and scan counter
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        bcd_d       = o_bcd;
        scan_d      = scan_q;
        idx_d       = idx_q;

        if (clk_en) begin
            case (state_q)
                S_IDLE: begin
                    if (i_load_enable || pend_q) begin
                        shift_d = i_load_enable ? i_load_data : pend_data_q;
                        acc_d   = '0;
                        cnt_d   = '0;
                        pend_d  = 1'b0;
                        state_d = S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    acc_d   = step_c[BCD_W+WIDTH-1:WIDTH];
                    shift_d = step_c[WIDTH-1:0];
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        bcd_d   = step_c[BCD_W+WIDTH-1:WIDTH];
                        state_d = S_IDLE;
                    end
                    if (i_load_enable) begin
                        pend_d      = 1'b1;
                        pend_data_d = i_load_data;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
                scan_d = '0;
                idx_d  = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                scan_d = scan_q + SCAN_W'(1);
            end
        end
    end

    // Display outputs are computed from next-state values so they register in step with o_bcd
    always_comb begin
        cur_digit_c = 4'd0;
        nz_above_c  = 1'b0;
        sel_d       = '0;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (IDX_W'(d) == idx_d) begin
                cur_digit_c = bcd_d[4*d +: 4];
                sel_d[d]    = 1'b1;
            end
            if ((IDX_W'(d) >= idx_d) && (bcd_d[4*d +: 4] != 4'd0)) begin
                nz_above_c = 1'b1;
            end
        end
        seg_d = dec_seg_c;
        if (BLANK_LZ && (idx_d != '0) && !nz_above_c) begin
            seg_d = 7'b0000000;
        end
        busy_d = (state_d == S_CONVERT) || pend_d;
    end

    seg7_decode u_seg7_decode (
        .bcd   (cur_digit_c),
        .seg_c (dec_seg_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            o_bcd       <= '0;
            scan_q      <= '0;
            idx_q       <= '0;
            o_seg       <= SEG_0;
            o_digit_sel <= DIGITS'(1);
            o_busy      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            o_bcd       <= bcd_d;
            scan_q      <= scan_d;
            idx_q       <= idx_d;
            o_seg       <= seg_d;
            o_digit_sel <= sel_d;
            o_busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_out_display_ctrl.sv
// Self-checking bench for out_display_ctrl against a transaction-level reference model.
module tb_out_display_ctrl;

    localparam int WIDTH    = 8;
    localparam int DIGITS   = 3;
    localparam int SCAN_DIV = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                clk_en = 1'b0;
    logic                i_load_enable = 1'b0;
    logic [WIDTH-1:0]    i_load_data = '0;
    logic [4*DIGITS-1:0] o_bcd;
    logic [6:0]          o_seg;
    logic [DIGITS-1:0]   o_digit_sel;
    logic                o_busy;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: numbers, not registers
    int en_cnt, conv_left, conv_val, pend_val, shown;
    bit pend_v;

    out_display_ctrl #(
        .WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .i_load_enable(i_load_enable), .i_load_data(i_load_data),
        .o_bcd(o_bcd), .o_seg(o_seg), .o_digit_sel(o_digit_sel), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [11:0] exp_bcd();
        return 12'((shown / 100 % 10) * 256 + (shown / 10 % 10) * 16 + shown % 10);
    endfunction

    function automatic int exp_idx();
        return (en_cnt / SCAN_DIV) % DIGITS;
    endfunction

    function automatic logic [2:0] exp_sel();
        return 3'(1 << exp_idx());
    endfunction

    function automatic logic [6:0] exp_seg();
        int p = 1;
        for (int i = 0; i < exp_idx(); i++) p = p * 10;
        if (exp_idx() > 0 && shown < p) return 7'h00;
        return glyph((shown / p) % 10);
    endfunction

    function automatic logic exp_busy();
        return (conv_left > 0) || pend_v;
    endfunction

    task automatic model_reset();
        en_cnt = 0; conv_left = 0; conv_val = 0; pend_val = 0; shown = 0; pend_v = 0;
    endtask

    task automatic model_step(input bit en, input bit ld, input int data);
        if (!en) return;
        en_cnt++;
        if (conv_left > 0) begin
            conv_left--;
            if (conv_left == 0) shown = conv_val;
            if (ld) begin pend_v = 1; pend_val = data; end
        end else if (ld || pend_v) begin
            conv_val  = ld ? data : pend_val;
            pend_v    = 0;
            conv_left = WIDTH;
        end
    endtask

    // One clock: drive inputs, advance model on the edge, settle 1 time unit after
    task automatic cycle(input bit en, input bit ld, input int data);
        clk_en = en; i_load_enable = ld; i_load_data = WIDTH'(data);
        @(posedge clk);
        model_step(en, ld, data);
        #1;
        i_load_enable = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; clk_en = 1'b0; i_load_enable = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        compared++; if (o_bcd !== 12'h000) begin mismatched++; $display("FAIL reset_bcd got %h want 000", o_bcd); end
        compared++; if (o_seg !== 7'b0111111) begin mismatched++; $display("FAIL reset_seg got %b want 0111111", o_seg); end
        compared++; if (o_digit_sel !== 3'b001) begin mismatched++; $display("FAIL reset_sel got %b want 001", o_digit_sel); end
        compared++; if (o_busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", o_busy); end
    endtask

    task automatic test_load_255();
        int busy_cnt = 0;
        bit found = 0;
        cycle(1, 1, 255);
        for (int k = 0; k < 10; k++) begin
            if (o_busy === 1'b1) busy_cnt++;
            compared++; if (o_bcd !== exp_bcd()) begin mismatched++; $display("FAIL l255_bcd k=%0d got %h want %h", k, o_bcd, exp_bcd()); end
            compared++; if (o_busy !== exp_busy()) begin mismatched++; $display("FAIL l255_busy k=%0d got %b want %b", k, o_busy, exp_busy()); end
            cycle(1, 0, 0);
        end
        compared++; if (busy_cnt != 8) begin mismatched++; $display("FAIL l255_busy_len got %0d want 8", busy_cnt); end
        compared++; if (o_bcd !== 12'h255) begin mismatched++; $display("FAIL l255_result got %h want 255", o_bcd); end
        for (int k = 0; k < 8 && !found; k++) begin
            if (o_digit_sel === 3'b001) found = 1; else cycle(1, 0, 0);
        end
        compared++; if (!found || o_seg !== 7'b1101101) begin mismatched++; $display("FAIL l255_seg0 got %b want 1101101", o_seg); end
    endtask

    task automatic test_zero_blank();
        logic [6:0] want [3] = '{7'b0111111, 7'b0000000, 7'b0000000};
        cycle(1, 1, 0);
        for (int k = 0; k < 10; k++) cycle(1, 0, 0);
        compared++; if (o_bcd !== 12'h000) begin mismatched++; $display("FAIL zero_bcd got %h want 000", o_bcd); end
        for (int d = 0; d < DIGITS; d++) begin
            logic [2:0] sel = 3'(1 << d);
            bit found = 0;
            for (int k = 0; k < 8 && !found; k++) begin
                if (o_digit_sel === sel) found = 1; else cycle(1, 0, 0);
            end
            compared++; if (!found || o_seg !== want[d]) begin mismatched++; $display("FAIL zero_seg d%0d got %b want %b", d, o_seg, want[d]); end
        end
    endtask

    task automatic test_pending();
        bit saw7 = 0;
        cycle(1, 1, 42);
        for (int k = 1; k <= 20; k++) begin
            cycle(1, (k == 3) || (k == 5), (k == 3) ? 7 : 9);
            if (o_bcd === 12'h007) saw7 = 1;
            compared++; if (o_bcd !== exp_bcd() || o_busy !== exp_busy() || o_seg !== exp_seg() || o_digit_sel !== exp_sel()) begin
                mismatched++;
                $display("FAIL pend_model k=%0d got bcd=%h busy=%b seg=%b sel=%b want %h %b %b %b",
                         k, o_bcd, o_busy, o_seg, o_digit_sel, exp_bcd(), exp_busy(), exp_seg(), exp_sel());
            end
            if (k == 8) begin
                compared++; if (o_bcd !== 12'h042 || o_busy !== 1'b1) begin mismatched++; $display("FAIL pend_first got %h busy=%b want 042 busy=1", o_bcd, o_busy); end
            end
            if (k == 16) begin
                compared++; if (o_bcd !== 12'h042 || o_busy !== 1'b1) begin mismatched++; $display("FAIL pend_hold got %h busy=%b want 042 busy=1", o_bcd, o_busy); end
            end
            if (k == 17) begin
                compared++; if (o_bcd !== 12'h009 || o_busy !== 1'b0) begin mismatched++; $display("FAIL pend_second got %h busy=%b want 009 busy=0", o_bcd, o_busy); end
            end
        end
        compared++; if (saw7) begin mismatched++; $display("FAIL pend_never7 got shown want hidden"); end
    endtask

    task automatic test_clk_en_duty();
        int en_seen = 0, done_at = -1;
        logic [11:0] pb; logic [6:0] ps; logic [2:0] pl; logic pbz;
        cycle(1, 1, 128);
        for (int k = 1; k <= 60; k++) begin
            bit en = (k % 4 == 0);
            pb = o_bcd; ps = o_seg; pl = o_digit_sel; pbz = o_busy;
            cycle(en, 0, 0);
            if (en) en_seen++;
            if (done_at < 0 && o_bcd === 12'h128) done_at = en_seen;
            if (!en) begin
                compared++; if (o_bcd !== pb || o_seg !== ps || o_digit_sel !== pl || o_busy !== pbz) begin
                    mismatched++; $display("FAIL duty_freeze k=%0d outputs changed with clk_en low", k);
                end
            end
            compared++; if (o_bcd !== exp_bcd() || o_busy !== exp_busy() || o_seg !== exp_seg() || o_digit_sel !== exp_sel()) begin
                mismatched++;
                $display("FAIL duty_model k=%0d got bcd=%h busy=%b seg=%b sel=%b want %h %b %b %b",
                         k, o_bcd, o_busy, o_seg, o_digit_sel, exp_bcd(), exp_busy(), exp_seg(), exp_sel());
            end
        end
        compared++; if (done_at != 8) begin mismatched++; $display("FAIL duty_latency got %0d want 8", done_at); end
    endtask

    task automatic test_reset_mid();
        cycle(1, 1, 100);
        for (int k = 1; k <= 4; k++) cycle(1, k == 2, 55);
        compared++; if (o_busy !== 1'b1) begin mismatched++; $display("FAIL rmid_pre_busy got %b want 1", o_busy); end
        rst_n = 1'b0;
        #1;
        model_reset();
        compared++; if (o_bcd !== 12'h000 || o_busy !== 1'b0 || o_digit_sel !== 3'b001 || o_seg !== 7'b0111111) begin
            mismatched++; $display("FAIL rmid_reset got bcd=%h busy=%b sel=%b seg=%b want 000 0 001 0111111", o_bcd, o_busy, o_digit_sel, o_seg);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle(1, 0, 0);
            compared++; if (o_bcd !== 12'h000 || o_busy !== 1'b0) begin
                mismatched++; $display("FAIL rmid_after k=%0d got bcd=%h busy=%b want 000 0", k, o_bcd, o_busy);
            end
        end
    endtask

    task automatic test_scan();
        logic [2:0] want [7] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
        apply_reset();
        for (int n = 0; n < 7; n++) begin
            compared++; if (o_digit_sel !== want[n]) begin mismatched++; $display("FAIL scan n=%0d got %b want %b", n, o_digit_sel, want[n]); end
            cycle(1, 0, 0);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            bit en = ($urandom_range(3, 0) != 0);
            bit ld = ($urandom_range(9, 0) < 2);
            cycle(en, ld, int'($urandom_range(255, 0)));
            compared++; if (o_bcd !== exp_bcd() || o_busy !== exp_busy() || o_seg !== exp_seg() || o_digit_sel !== exp_sel()) begin
                mismatched++;
                $display("FAIL rand k=%0d got bcd=%h busy=%b seg=%b sel=%b want %h %b %b %b",
                         k, o_bcd, o_busy, o_seg, o_digit_sel, exp_bcd(), exp_busy(), exp_seg(), exp_sel());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_255();
        test_zero_blank();
        test_pending();
        test_clk_en_duty();
        test_reset_mid();
        test_scan();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/out_display_ctrl.md
OUT_DISPLAY_CTRL -- requirements
Module: out_display_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of the binary output value.
REQ-002 SHALL have parameter DIGITS, default 3, number of BCD digits and display positions; DIGITS*3.33 >= WIDTH.
REQ-003 SHALL have parameter SCAN_DIV, default 1024, number of clk_en cycles each digit is driven.
REQ-004 SHALL have parameter BLANK_LZ, default 1, which enables leading-zero blanking when 1.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk, input, 1, the system clock.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port clk_en, input, 1, global step enable; all state advances only when it is high.
REQ-009 SHALL have port i_load_enable, input, 1, request to latch a new value.
REQ-010 SHALL have port i_load_data, input, WIDTH, binary value to display.
REQ-011 SHALL have port o_bcd, output, 4*DIGITS, last completed BCD result, digit 0 at LSBs.
REQ-012 SHALL have port o_seg, output, 7, segments {g,f,e,d,c,b,a}, active-high.
REQ-013 SHALL have port o_digit_sel, output, DIGITS, one-hot active-high digit enable.
REQ-014 SHALL have port o_busy, output, 1, high while a conversion is in progress or pending.

Function
REQ-015 SHALL accept a load only when clk_en & i_load_enable are both high at a rising clk edge.
REQ-016 SHALL implement FSM states IDLE and CONVERT.
REQ-017 SHALL, in IDLE on an accepted load, capture i_load_data into the shift register, clear the BCD accumulator, zero the bit counter and go to CONVERT.
REQ-018 SHALL, in CONVERT, perform one double-dabble step per clk_en cycle: add 3 to every digit >= 5, then shift left one bit.
REQ-019 SHALL complete conversion after exactly WIDTH clk_en cycles, update o_bcd atomically on the final step, then return to IDLE.
REQ-020 SHALL hold o_bcd at its previous value throughout CONVERT, with no partial results visible.
REQ-021 SHALL, on a load accepted during CONVERT, store the value in a pending register (last value wins) and set the pending flag.
REQ-022 SHALL, on completion with pending set, start conversion of the pending value on the next clk_en cycle and clear the flag.
REQ-023 SHALL, on a load coincident with the final CONVERT step, treat it as pending.
REQ-024 SHALL drive o_busy = (state==CONVERT) | pending.
REQ-025 SHALL advance the digit index every SCAN_DIV clk_en cycles, wrapping from DIGITS-1 to 0; scanning is independent of conversion.
REQ-026 SHALL drive o_digit_sel = one-hot of the digit index, and o_seg = decode of o_bcd digit[index].
REQ-027 SHALL, when BLANK_LZ=1, force o_seg=0 for a zero digit above the most significant nonzero digit; digit 0 is never blanked.
REQ-028 SHALL decode BCD values 10-15 to o_seg=0, a defensive case that is unreachable.
REQ-029 SHALL freeze all state, including the scan counter, while clk_en is low; outputs remain stable.

Reset
REQ-030 SHALL, on rst_n low, immediately set the FSM to IDLE; clear o_bcd, pending, the shift register and all counters; and set the digit index to 0.
REQ-031 SHALL, in reset, output o_digit_sel = 1 (digit 0), o_seg = 7'b0111111 ("0"), and o_busy = 0.
REQ-032 SHALL abandon any conversion and pending value when reset is asserted mid-operation.

Structure
REQ-033 SHALL place the FSM state enum and the 7-segment glyph constants for 0-9 in a shared package, out_display_pkg.
REQ-034 SHALL implement segment decode as the combinational sub-module seg7_decode (4-bit in, 7-bit out).
REQ-035 SHALL use no other sub-modules; the BCD shifter and scan counter live in out_display_ctrl.

Verification
REQ-036 SHALL cover: reset, then load 255 -> o_busy high for 8 clk_en cycles; o_bcd=12'h255; digit 0 o_seg=7'b1101101.
REQ-037 SHALL cover: load 0 with BLANK_LZ=1 -> o_bcd=0; digits 2 and 1 o_seg=0; digit 0 o_seg=7'b0111111.
REQ-038 SHALL cover: load 42, then load 7 at step 3 and load 9 at step 5 -> o_bcd=042 then 009; 7 is never shown; o_busy falls 8 cycles after the 9 conversion starts.
REQ-039 SHALL cover: clk_en toggled 1/4 duty during conversion of 128 -> result 128 after exactly 8 enabled cycles; scan stalls accordingly.
REQ-040 SHALL cover: rst_n pulsed low at CONVERT step 4 with pending set -> IDLE, o_bcd=0, o_busy=0, and no later conversion.
REQ-041 SHALL cover: SCAN_DIV=2 -> o_digit_sel sequence 001,010,100,001, each held for 2 clk_en cycles.
